control_to_network_bridge_arbiter: RTL
======================================

# control_to_network_bridge_arbiter

Packet-level round-robin arbiter that shares the single control-path AXI-Stream link toward the network bridge between two sources: the AXI-Lite to Network Converter (ANC, outgoing requests) and the Network to AXI-Lite Converter (NAC, responses). It is the transmit-side counterpart of the control splitter. It never interleaves beats of different packets, registers its output through a 2-entry skid buffer, and exposes per-source packet counters for debug.

## Interface
- AXIS_DATA_WIDTH, 128, tdata width of all streams
- AXIS_KEEP_WIDTH, 16, tkeep width (AXIS_DATA_WIDTH/8)
- AXIS_TDEST_WIDTH, 8, tid and tdest width
- AXIS_TUSER_WIDTH, 32, tuser width
- PKT_CNT_WIDTH, 16, width of packet counters
---
- i_clk  in  1  sole clock
- i_ap_rst_n  in  1  reset; asynchronous, active-low
- from_anc_{tvalid,tready,tdata,tkeep,tid,tdest,tuser,tlast}  in (tready out)  1/1/DATA/KEEP/TDEST/TDEST/TUSER/1  ANC source stream
- from_nac_{tvalid,tready,tdata,tkeep,tid,tdest,tuser,tlast}  in (tready out)  same widths  NAC source stream
- to_network_bridge_{tvalid,tready,tdata,tkeep,tid,tdest,tuser,tlast}  out (tready in)  same widths  merged stream
- o_anc_pkt_count  out  PKT_CNT_WIDTH  ANC packets forwarded
- o_nac_pkt_count  out  PKT_CNT_WIDTH  NAC packets forwarded

## Operation
- States: IDLE, GRANT_ANC, GRANT_NAC. Register last_grant (ANC/NAC).
- IDLE: only ANC valid -> GRANT_ANC; only NAC valid -> GRANT_NAC; both valid -> grant the source not equal to last_grant; neither -> stay. last_grant updated on entry to a GRANT state.
- GRANT_x: from_x_tready = skid_in_ready; other source tready = 0. All sidebands (tdata, tkeep, tid, tdest, tuser, tlast) passed unmodified.
- Accepted beat (tvalid && tready) with tlast=1 in GRANT_x -> IDLE next cycle; x packet counter += 1 (wraps modulo 2^PKT_CNT_WIDTH).
- A granted source with tvalid low mid-packet keeps the grant; no timeout.
- tready in IDLE is 0 for both sources.
- Skid buffer: 2 entries; skid_in_ready registered, = 1 when at least one entry is free at the start of the cycle; output tvalid/tdata held stable while tready low (AXIS rule).

## Timing
- Reset (async assert, sync deassert assumed upstream): state IDLE, last_grant=NAC (ANC wins first tie), both from_*_tready=0, to_network_bridge_tvalid=0, skid empty, counters 0. Other output data fields don't-care while tvalid=0.
- Arbitration: source valid in IDLE at cycle N -> tready high at N+1 (if skid not full).
- Data latency: beat accepted at cycle N -> to_network_bridge_tvalid at N+1.
- Packet boundary cost: one idle cycle (IDLE) between consecutive packets; a single-beat packet uses 2 cycles of arbiter time.
- Full throughput within a packet when to_network_bridge_tready held high.
- Backpressure: to_network_bridge_tready low -> skid fills after 2 further beats, then source tready drops; no beat lost or duplicated.
- Simultaneous: tlast accepted and other source valid in same cycle -> IDLE next cycle, other source granted the cycle after.
- Reset mid-packet: partial packet discarded from skid, counters cleared; downstream must tolerate truncation.

## Structure
- Shared package ctrl_api_pkg: AXIS width constants (shared with splitter), grant_state_t enum {IDLE, GRANT_ANC, GRANT_NAC}, source_e {SRC_ANC, SRC_NAC}.
- Sub-module axis_skid_buffer (2-entry, parameterized on packed payload width = DATA+KEEP+2*TDEST+TUSER+1); reusable elsewhere on the control path.
- Top holds FSM, mux, counters.

## Test plan
- Reset: hold i_ap_rst_n low 10 cycles -> all tready/tvalid 0, counters 0; release -> still idle with no inputs.
- ANC only: single-beat packet tdata='h3ABABABABABABA, tid='hFE, tuser='hAAAABBBB, tlast=1 -> appears unchanged on to_network_bridge 1 cycle after acceptance; o_anc_pkt_count=1.
- Tie: both sources present single-beat packets at same cycle, repeated 4 times -> output order ANC,NAC,ANC,NAC; counts 2/2.
- No interleave: ANC 3-beat packet with tvalid gap on beat 2, NAC valid throughout -> all 3 ANC beats contiguous in output order before any NAC beat.
- Backpressure: to_network_bridge_tready low 5 cycles during NAC 4-beat packet -> from_nac_tready drops after 2 beats buffered; output beats in order, tdata/tkeep stable while stalled, none lost.
- Reset mid-packet: assert reset during beat 2 of 3 -> tvalid 0 immediately, counters 0, next packet after release delivered intact.

Source files
------------

// File: rtl/ctrl_api_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_api_pkg
// Shared definitions for the control-path AXI-Stream blocks (splitter and
// arbiter): stream field widths, the arbiter grant state encoding and the
// source identifiers.
// ----------------------------------------------------------------------------
package ctrl_api_pkg;

    localparam int CTRL_AXIS_DATA_WIDTH  = 128;
    localparam int CTRL_AXIS_KEEP_WIDTH  = CTRL_AXIS_DATA_WIDTH / 8;
    localparam int CTRL_AXIS_TDEST_WIDTH = 8;
    localparam int CTRL_AXIS_TUSER_WIDTH = 32;
    localparam int CTRL_PKT_CNT_WIDTH    = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_ANC = 2'd1,
        GRANT_NAC = 2'd2
    } grant_state_t;

    typedef enum logic {
        SRC_ANC = 1'b0,
        SRC_NAC = 1'b1
    } source_e;

    // Width of one stream beat packed as {tlast, tuser, tdest, tid, tkeep, tdata}.
    function automatic int axis_payload_width(input int data_w, input int keep_w,
                                              input int tdest_w, input int tuser_w);
        return data_w + keep_w + 2 * tdest_w + tuser_w + 1;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// ----------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry register slice for a packed AXI-Stream payload. Both the output
// (valid/data) and the upstream ready are registered, which breaks every
// combinational path through the block.
//
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset (buffer empties)
//   s_valid_i/s_ready_o/s_data_i   upstream side
//   m_valid_o/m_ready_i/m_data_o   downstream side; data held while stalled
// ----------------------------------------------------------------------------
module axis_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             ready_q;
    logic             push;
    logic             pop;

    assign push = s_valid_i && ready_q;
    assign pop  = (count_q != 2'd0) && m_ready_i;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    // ready is the registered "an entry will be free next cycle" flag, so a
    // push can never land on a full buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= 2'd0;
            ready_q  <= 1'b1;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            ready_q <= (count_d != 2'd2);
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Payload storage needs no reset: it is only observed while count_q != 0.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= s_data_i;
    end

    assign s_ready_o = ready_q;
    assign m_valid_o = (count_q != 2'd0);
    assign m_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/control_to_network_bridge_arbiter.sv
// ----------------------------------------------------------------------------
// control_to_network_bridge_arbiter
// Packet-level round-robin arbiter merging the ANC (requests) and NAC
// (responses) control streams onto the single link toward the network bridge.
// A grant is held for a whole packet, so beats of different packets never
// interleave. The merged stream leaves through a 2-entry skid buffer.
//
// Ports:
//   i_clk, i_ap_rst_n               clock, asynchronous active-low reset
//   from_anc_*                      ANC source stream (tready is an output)
//   from_nac_*                      NAC source stream (tready is an output)
//   to_network_bridge_*             merged stream (tready is an input)
//   o_anc_pkt_count/o_nac_pkt_count packets forwarded per source (wrapping)
//   o_dbg_state                     current grant state, for observation
//
// Handshake: a beat moves on a port in the cycle where tvalid and tready are
// both high at the rising clock edge; a source holds tvalid and all payload
// fields stable until accepted, and tvalid never depends on tready.
// ----------------------------------------------------------------------------
module control_to_network_bridge_arbiter
    import ctrl_api_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH  = CTRL_AXIS_DATA_WIDTH,
    parameter int AXIS_KEEP_WIDTH  = CTRL_AXIS_KEEP_WIDTH,
    parameter int AXIS_TDEST_WIDTH = CTRL_AXIS_TDEST_WIDTH,
    parameter int AXIS_TUSER_WIDTH = CTRL_AXIS_TUSER_WIDTH,
    parameter int PKT_CNT_WIDTH    = CTRL_PKT_CNT_WIDTH
) (
    input  logic                        i_clk,
    input  logic                        i_ap_rst_n,

    input  logic                        from_anc_tvalid,
    output logic                        from_anc_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]  from_anc_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]  from_anc_tkeep,
    input  logic [AXIS_TDEST_WIDTH-1:0] from_anc_tid,
    input  logic [AXIS_TDEST_WIDTH-1:0] from_anc_tdest,
    input  logic [AXIS_TUSER_WIDTH-1:0] from_anc_tuser,
    input  logic                        from_anc_tlast,

    input  logic                        from_nac_tvalid,
    output logic                        from_nac_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]  from_nac_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]  from_nac_tkeep,
    input  logic [AXIS_TDEST_WIDTH-1:0] from_nac_tid,
    input  logic [AXIS_TDEST_WIDTH-1:0] from_nac_tdest,
    input  logic [AXIS_TUSER_WIDTH-1:0] from_nac_tuser,
    input  logic                        from_nac_tlast,

    output logic                        to_network_bridge_tvalid,
    input  logic                        to_network_bridge_tready,
    output logic [AXIS_DATA_WIDTH-1:0]  to_network_bridge_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]  to_network_bridge_tkeep,
    output logic [AXIS_TDEST_WIDTH-1:0] to_network_bridge_tid,
    output logic [AXIS_TDEST_WIDTH-1:0] to_network_bridge_tdest,
    output logic [AXIS_TUSER_WIDTH-1:0] to_network_bridge_tuser,
    output logic                        to_network_bridge_tlast,

    output logic [PKT_CNT_WIDTH-1:0]    o_anc_pkt_count,
    output logic [PKT_CNT_WIDTH-1:0]    o_nac_pkt_count,
    output grant_state_t                o_dbg_state
);

    localparam int PW = axis_payload_width(AXIS_DATA_WIDTH, AXIS_KEEP_WIDTH,
                                           AXIS_TDEST_WIDTH, AXIS_TUSER_WIDTH);

    grant_state_t             state_q;
    source_e                  last_grant_q;
    logic [PKT_CNT_WIDTH-1:0] anc_cnt_q;
    logic [PKT_CNT_WIDTH-1:0] nac_cnt_q;

    logic          skid_in_valid;
    logic          skid_in_ready;
    logic [PW-1:0] skid_in_data;
    logic [PW-1:0] skid_out_data;
    logic          last_fire;

    // Payload mux: only the granted source reaches the skid buffer.
    always_comb begin
        skid_in_valid = 1'b0;
        skid_in_data  = '0;
        case (state_q)
            GRANT_ANC: begin
                skid_in_valid = from_anc_tvalid;
                skid_in_data  = {from_anc_tlast, from_anc_tuser, from_anc_tdest,
                                 from_anc_tid, from_anc_tkeep, from_anc_tdata};
            end
            GRANT_NAC: begin
                skid_in_valid = from_nac_tvalid;
                skid_in_data  = {from_nac_tlast, from_nac_tuser, from_nac_tdest,
                                 from_nac_tid, from_nac_tkeep, from_nac_tdata};
            end
            default: ;
        endcase
    end

    assign from_anc_tready = (state_q == GRANT_ANC) && skid_in_ready;
    assign from_nac_tready = (state_q == GRANT_NAC) && skid_in_ready;
    assign last_fire       = skid_in_valid && skid_in_ready && skid_in_data[PW-1];

    // Arbitration FSM. On a tie the source that did not hold the previous
    // grant wins; last_grant resets to NAC so ANC wins the first tie.
    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= SRC_NAC;
            anc_cnt_q    <= '0;
            nac_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (from_anc_tvalid && (!from_nac_tvalid || last_grant_q == SRC_NAC)) begin
                        state_q      <= GRANT_ANC;
                        last_grant_q <= SRC_ANC;
                    end else if (from_nac_tvalid) begin
                        state_q      <= GRANT_NAC;
                        last_grant_q <= SRC_NAC;
                    end
                end
                GRANT_ANC: begin
                    if (last_fire) begin
                        state_q   <= IDLE;
                        anc_cnt_q <= anc_cnt_q + PKT_CNT_WIDTH'(1);
                    end
                end
                GRANT_NAC: begin
                    if (last_fire) begin
                        state_q   <= IDLE;
                        nac_cnt_q <= nac_cnt_q + PKT_CNT_WIDTH'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    axis_skid_buffer #(
        .WIDTH (PW)
    ) u_skid (
        .clk_i     (i_clk),
        .rst_ni    (i_ap_rst_n),
        .s_valid_i (skid_in_valid),
        .s_ready_o (skid_in_ready),
        .s_data_i  (skid_in_data),
        .m_valid_o (to_network_bridge_tvalid),
        .m_ready_i (to_network_bridge_tready),
        .m_data_o  (skid_out_data)
    );

    assign {to_network_bridge_tlast, to_network_bridge_tuser, to_network_bridge_tdest,
            to_network_bridge_tid, to_network_bridge_tkeep, to_network_bridge_tdata} = skid_out_data;

    assign o_anc_pkt_count = anc_cnt_q;
    assign o_nac_pkt_count = nac_cnt_q;
    assign o_dbg_state     = state_q;

endmodule
